// File: rtl/pzbcm_width_downsizer_pkg.sv
// Shared types and width helpers for the wide-to-narrow serializer.
package pzbcm_width_downsizer_pkg;

    // Serializer state: IDLE waits for a word, BUSY is emitting beats.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Width of one output beat.
    function automatic int calc_out_width(int in_width, int ratio);
        return in_width / ratio;
    endfunction

    // Width of the beat index / beat count fields (at least one bit).
    function automatic int calc_beat_w(int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/pzbcm_width_downsizer.sv
// Valid/ready wide-to-narrow serializer: one IN_WIDTH word in, up to RATIO
// OUT_WIDTH beats out, final beat flagged with o_last. A new word is taken in
// the same cycle the last beat leaves, so consecutive words have no bubble.
//
// Handshake: a transfer happens on a rising i_clk edge where valid && ready;
// a source holding valid keeps its payload stable until that edge, and the
// only combinational input-to-output path is i_ready -> o_ready.
module pzbcm_width_downsizer
    import pzbcm_width_downsizer_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = calc_out_width(IN_WIDTH, RATIO),
    parameter int BEAT_W    = calc_beat_w(RATIO),
    parameter int LSB_FIRST = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic [BEAT_W-1:0]    i_beats,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_last
);

    // Parameter sanity at elaboration.
    if ((IN_WIDTH % RATIO) != 0) begin : g_bad_in_width
        $error("pzbcm_width_downsizer: IN_WIDTH must be a multiple of RATIO");
    end
    if (RATIO < 2) begin : g_bad_ratio
        $error("pzbcm_width_downsizer: RATIO must be >= 2");
    end

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] data_q,  data_d;
    logic [BEAT_W-1:0]   idx_q,   idx_d;
    logic [BEAT_W-1:0]   end_q,   end_d;   // beat count minus one

    logic                accept;
    logic                beat_hs;
    logic [BEAT_W-1:0]   sel;
    logic [OUT_WIDTH-1:0] slices [RATIO];

    assign o_valid = (state_q == BUSY);
    assign o_last  = (state_q == BUSY) && (idx_q == end_q);
    assign o_ready = (state_q == IDLE) || (o_valid && i_ready && o_last);
    assign accept  = i_valid && o_ready;
    assign beat_hs = o_valid && i_ready;

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign slices[g] = data_q[g*OUT_WIDTH +: OUT_WIDTH];
    end

    // Pick the current beat slice in the configured order.
    always_comb begin
        sel = idx_q;
        if (LSB_FIRST == 0) begin
            sel = BEAT_W'(RATIO - 1) - idx_q;
        end
        o_data = slices[sel];
    end

    // Next-state: advance within a word, reload on accept (overrides the
    // drop to IDLE so the last beat and the next word overlap).
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        end_d   = end_q;
        if (beat_hs) begin
            if (!o_last) begin
                idx_d = idx_q + BEAT_W'(1);
            end else begin
                state_d = IDLE;
            end
        end
        if (accept) begin
            data_d  = i_data;
            idx_d   = '0;
            end_d   = i_beats - BEAT_W'(1);
            state_d = BUSY;
        end
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
        end
    end

    // Beat counts above RATIO only exist when RATIO is not a power of two.
    if ((1 << BEAT_W) != RATIO) begin : g_beats_chk
        property p_beats_legal;
            @(posedge i_clk) disable iff (i_rst)
                (accept && (i_beats != '0)) |-> (int'(i_beats) <= RATIO);
        endproperty
        a_beats_legal : assert property (p_beats_legal)
            else $error("pzbcm_width_downsizer: i_beats exceeds RATIO");
    end

endmodule
